// File: rtl/tdm_demux4.sv
// TDM receive demultiplexer: splits a 4-slot framed sample stream into four channel registers.
// Optional macro TDM_DEMUX_ERRCNT_EN adds a saturating 8-bit framing-error counter output.
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic             locked,
`ifdef TDM_DEMUX_ERRCNT_EN
    output logic             sync_err,
    output logic [7:0]       err_count
`else
    output logic             sync_err
`endif
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] slot0_p0, slot1_p0, slot2_p0;
    logic [WIDTH-1:0] slot0_d, slot1_d, slot2_d;
    logic [WIDTH-1:0] ch0_d, ch1_d, ch2_d, ch3_d;
    logic             frame_valid_d;
    logic             sync_err_d;

    // State, staging and output registers; async reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            slot0_p0    <= '0;
            slot1_p0    <= '0;
            slot2_p0    <= '0;
            ch0         <= '0;
            ch1         <= '0;
            ch2         <= '0;
            ch3         <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            slot0_p0    <= slot0_d;
            slot1_p0    <= slot1_d;
            slot2_p0    <= slot2_d;
            ch0         <= ch0_d;
            ch1         <= ch1_d;
            ch2         <= ch2_d;
            ch3         <= ch3_d;
            frame_valid <= frame_valid_d;
            sync_err    <= sync_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        slot0_d       = slot0_p0;
        slot1_d       = slot1_p0;
        slot2_d       = slot2_p0;
        ch0_d         = ch0;
        ch1_d         = ch1;
        ch2_d         = ch2;
        ch3_d         = ch3;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_start) begin
                        slot0_d = din;
                        slot_d  = 2'd1;
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_start) begin
                        // A slot0 tag anywhere but slot 0 restarts the frame and flags the break.
                        sync_err_d = (slot_q != 2'd0);
                        slot0_d    = din;
                        slot_d     = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd0: begin
                                sync_err_d = 1'b1;
                                slot_d     = 2'd0;
                                state_d    = HUNT;
                            end
                            2'd1: begin
                                slot1_d = din;
                                slot_d  = 2'd2;
                            end
                            2'd2: begin
                                slot2_d = din;
                                slot_d  = 2'd3;
                            end
                            default: begin
                                ch0_d         = slot0_p0;
                                ch1_d         = slot1_p0;
                                ch2_d         = slot2_p0;
                                ch3_d         = din;
                                frame_valid_d = 1'b1;
                                slot_d        = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign locked = (state_q == LOCKED);

`ifdef TDM_DEMUX_ERRCNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (sync_err_d) begin
            err_count <= sat_inc8(err_count);
        end
    end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (WIDTH=4) against a queue-based frame model.
// Build with TDM_DEMUX_ERRCNT_EN defined to also exercise the error counter.
module tb_tdm_demux4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic         frame_valid, locked, sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0]   err_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: the current partial frame is a queue of accepted samples.
    logic         m_locked;
    logic [W-1:0] m_ch [4];
    logic         m_fv, m_se;
    int           m_errs;
    logic [W-1:0] q [$];

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_start(frame_start),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .frame_valid(frame_valid), .locked(locked),
`ifdef TDM_DEMUX_ERRCNT_EN
        .sync_err(sync_err), .err_count(err_count)
`else
        .sync_err(sync_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic logic [18:0] dut_vec();
        return {ch0, ch1, ch2, ch3, frame_valid, locked, sync_err};
    endfunction

    function automatic logic [18:0] mdl_vec();
        return {m_ch[0], m_ch[1], m_ch[2], m_ch[3], m_fv, m_locked, m_se};
    endfunction

    task automatic model_clear();
        m_locked = 1'b0;
        for (int i = 0; i < 4; i++) m_ch[i] = '0;
        m_fv = 1'b0;
        m_se = 1'b0;
        m_errs = 0;
        q.delete();
    endtask

    // Apply one cycle of input, then advance the model by the same sample.
    task automatic drive(input logic v, input logic fs, input logic [W-1:0] d);
        din_valid = v;
        frame_start = fs;
        din = d;
        @(posedge clk);
        #1;
        m_fv = 1'b0;
        m_se = 1'b0;
        if (v) begin
            if (fs) begin
                if (m_locked && q.size() != 0) m_se = 1'b1;
                q.delete();
                q.push_back(d);
                m_locked = 1'b1;
            end else if (m_locked) begin
                if (q.size() == 0) begin
                    m_se = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    q.push_back(d);
                    if (q.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_ch[i] = q[i];
                        m_fv = 1'b1;
                        q.delete();
                    end
                end
            end
        end
        if (m_se && m_errs < 255) m_errs++;
        din_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic assert_rst();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_clear();
        #12;
        total++;
        if (dut_vec() !== 19'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h exp=%h", dut_vec(), 19'd0);
        end
        release_rst();
        total++;
        if (dut_vec() !== mdl_vec()) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_basic_frame();
        logic [5:0] s [4] = '{6'h31, 6'h22, 6'h23, 6'h24};
        for (int i = 0; i < 4; i++) begin
            drive(s[i][5], s[i][4], s[i][3:0]);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL basic[%0d] got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
            if (i == 0) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("FAIL basic_locked got=%b exp=1", locked);
                end
            end
        end
        total++;
        if ({ch0, ch1, ch2, ch3, frame_valid, sync_err} !== {16'h1234, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL basic_out got=%h%h%h%h fv=%b se=%b exp=1234 fv=1 se=0",
                     ch0, ch1, ch2, ch3, frame_valid, sync_err);
        end
        drive(1'b0, 1'b0, 4'h0);
        total++;
        if (frame_valid !== 1'b0 || {ch0, ch1, ch2, ch3} !== 16'h1234) begin
            bad++;
            $display("FAIL basic_hold fv=%b ch=%h%h%h%h exp fv=0 ch=1234", frame_valid, ch0, ch1, ch2, ch3);
        end
    endtask

    task automatic test_hunt_drop();
        logic [5:0] s [6] = '{6'h29, 6'h29, 6'h35, 6'h26, 6'h27, 6'h28};
        int fv_seen = 0;
        assert_rst();
        release_rst();
        for (int i = 0; i < 6; i++) begin
            drive(s[i][5], s[i][4], s[i][3:0]);
            if (frame_valid === 1'b1) fv_seen++;
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL hunt[%0d] got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
            if (i == 1) begin
                total++;
                if ({ch0, ch1, ch2, ch3, frame_valid, locked} !== 18'd0) begin
                    bad++;
                    $display("FAIL hunt_drop got=%h exp=0", {ch0, ch1, ch2, ch3, frame_valid, locked});
                end
            end
        end
        total++;
        if ({ch0, ch1, ch2, ch3} !== 16'h5678 || fv_seen != 1) begin
            bad++;
            $display("FAIL hunt_frame ch=%h%h%h%h fv_count=%0d exp ch=5678 fv_count=1", ch0, ch1, ch2, ch3, fv_seen);
        end
    endtask

    task automatic test_bubbles();
        logic [5:0] s [7] = '{6'h3A, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h2C, 6'h2D};
        int se_seen = 0;
        for (int i = 0; i < 7; i++) begin
            drive(s[i][5], s[i][4], s[i][3:0]);
            if (sync_err === 1'b1) se_seen++;
            total++;
            if (frame_valid !== (i == 6) || dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL bubble[%0d] got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
        total++;
        if ({ch0, ch1, ch2, ch3} !== 16'hABCD || se_seen != 0) begin
            bad++;
            $display("FAIL bubble_frame ch=%h%h%h%h se_count=%0d exp ch=ABCD se_count=0", ch0, ch1, ch2, ch3, se_seen);
        end
    endtask

    task automatic test_early_restart();
        logic [5:0] s [10] = '{6'h31, 6'h22, 6'h23, 6'h24,
                               6'h35, 6'h26, 6'h37, 6'h28, 6'h29, 6'h2A};
        for (int i = 0; i < 10; i++) begin
            drive(s[i][5], s[i][4], s[i][3:0]);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL restart[%0d] got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
            if (i == 6) begin
                total++;
                if ({sync_err, frame_valid, locked, ch0, ch1, ch2, ch3} !== {3'b101, 16'h1234}) begin
                    bad++;
                    $display("FAIL restart_err se=%b fv=%b lk=%b ch=%h%h%h%h exp se=1 fv=0 lk=1 ch=1234",
                             sync_err, frame_valid, locked, ch0, ch1, ch2, ch3);
                end
            end
        end
        total++;
        if ({ch0, ch1, ch2, ch3, frame_valid} !== {16'h789A, 1'b1}) begin
            bad++;
            $display("FAIL restart_frame ch=%h%h%h%h fv=%b exp ch=789A fv=1", ch0, ch1, ch2, ch3, frame_valid);
        end
    endtask

    task automatic test_slot0_err();
        logic [5:0] s [3] = '{6'h23, 6'h21, 6'h22};
        for (int i = 0; i < 3; i++) begin
            drive(s[i][5], s[i][4], s[i][3:0]);
            total++;
            if ({sync_err, locked} !== {(i == 0), 1'b0} || dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL slot0[%0d] got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] v;
        for (int i = 0; i < 12; i++) begin
            v = W'(i + 3);
            drive(1'b1, (i % 4) == 0, v);
            total++;
            if (frame_valid !== ((i % 4) == 3) || dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
        total++;
        if ({ch0, ch1, ch2, ch3} !== 16'hBCDE) begin
            bad++;
            $display("FAIL b2b_last ch=%h%h%h%h exp=BCDE", ch0, ch1, ch2, ch3);
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] s [6] = '{6'h31, 6'h22, 6'h23, 6'h24, 6'h35, 6'h26};
        for (int i = 0; i < 6; i++) drive(s[i][5], s[i][4], s[i][3:0]);
        total++;
        if ({ch0, ch1, ch2, ch3, locked} !== {16'h1234, 1'b1}) begin
            bad++;
            $display("FAIL async_pre ch=%h%h%h%h lk=%b exp ch=1234 lk=1", ch0, ch1, ch2, ch3, locked);
        end
        assert_rst();
        total++;
        if (dut_vec() !== 19'd0) begin
            bad++;
            $display("FAIL async_now got=%h exp=%h", dut_vec(), 19'd0);
        end
        release_rst();
        drive(1'b1, 1'b0, 4'h7);
        drive(1'b1, 1'b0, 4'h8);
        total++;
        if (dut_vec() !== mdl_vec() || locked !== 1'b0) begin
            bad++;
            $display("FAIL async_after got=%h exp=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_random();
        logic v, fs;
        logic [W-1:0] d;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            fs = ($urandom_range(0, 4) == 0);
            d  = W'($urandom);
            drive(v, fs, d);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
`ifdef TDM_DEMUX_ERRCNT_EN
            total++;
            if (err_count !== 8'(m_errs)) begin
                bad++;
                $display("FAIL random_errcnt[%0d] got=%0d exp=%0d", i, err_count, m_errs);
            end
`endif
        end
    endtask

`ifdef TDM_DEMUX_ERRCNT_EN
    task automatic test_errcnt();
        assert_rst();
        release_rst();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, W'(i + 1));
        total++;
        if (err_count !== 8'd3 || err_count !== 8'(m_errs)) begin
            bad++;
            $display("FAIL errcnt_three got=%0d exp=3", err_count);
        end
        assert_rst();
        total++;
        if (err_count !== 8'd0) begin
            bad++;
            $display("FAIL errcnt_reset got=%0d exp=0", err_count);
        end
        release_rst();
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, W'(i));
        total++;
        if (err_count !== 8'd255) begin
            bad++;
            $display("FAIL errcnt_sat got=%0d exp=255", err_count);
        end
        assert_rst();
        release_rst();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_hunt_drop();
        test_bubbles();
        test_early_restart();
        test_slot0_err();
        test_back_to_back();
        test_async_reset();
`ifdef TDM_DEMUX_ERRCNT_EN
        test_errcnt();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
